dm_access_ctrl: RTL

Data-memory access controller sitting directly downstream of the MEM stage, between MEM's data-memory port (`data_address_2DM`, `data_write_2DM`, `data_write_size_2DM`, `MemRead_2DM`, `MemWrite_2DM`, `data_read_fDM`) and a multi-cycle data memory with a req/ack handshake. It sequences loads, full-word stores and read-modify-write sub-word stores, and stalls the pipeline until each access completes. Sub-word and partial-word merging stays in MEM. This block only supplies the old word and writes back the merged word.

---
 rtl/dm_access_ctrl_if.sv | 28 ++
 rtl/dm_access_ctrl.sv | 94 +++++++++
 2 files changed

// File: rtl/dm_access_ctrl_if.sv
// Request/acknowledge bus between the data-memory access controller
// and a multi-cycle data memory.
interface dm_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Sequences loads, word stores and read-modify-write partial stores
// against a req/ack data memory, stalling the pipeline meanwhile.
module dm_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MemRead_IN,
  input  logic                    MemWrite_IN,
  input  logic [31:0]             Address_IN,
  input  logic [31:0]             WriteData_IN,
  input  logic [1:0]              WriteSize_IN,
  output logic [31:0]             ReadData_OUT,
  output logic                    STALL_OUT,
  output logic                    ERR_OUT,
  dm_access_ctrl_if.master        mem
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_store;
  logic          expired;

  assign expired = (cnt == CNT_LAST);

  assign mem.mem_req   = (state == READ) || (state == WRITE);
  assign mem.mem_we    = (state == WRITE);
  assign mem.mem_addr  = Address_IN & ~32'h3;
  assign mem.mem_wdata = (state == WRITE) ? WriteData_IN : 32'h0;

  assign STALL_OUT = (state == READ) || (state == WRITE) ||
                     ((state == IDLE) && (MemRead_IN || MemWrite_IN));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      cnt          <= '0;
      is_store     <= 1'b0;
      ReadData_OUT <= 32'h0;
      ERR_OUT      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (MemWrite_IN) begin
            is_store <= 1'b1;
            state    <= (WriteSize_IN == 2'd0) ? WRITE : READ;
          end else if (MemRead_IN) begin
            is_store <= 1'b0;
            state    <= READ;
          end
        end
        READ: begin
          if (mem.mem_ack) begin
            ReadData_OUT <= mem.mem_rdata;
            cnt          <= '0;
            state        <= is_store ? WRITE : DONE;
          end else if (expired) begin
            // Poison value so a dead load is recognisable downstream
            ReadData_OUT <= 32'hDEADBEEF;
            ERR_OUT      <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (mem.mem_ack) begin
            state <= DONE;
          end else if (expired) begin
            ERR_OUT <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
